// File: rtl/cacheline_adapter_if.sv
// Bus bundle between a cache's DFP port, the cacheline adapter and the burst memory.
// The adapter connects through the slave modport; the cache and memory side use master.
interface cacheline_adapter_if #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
);
  // Handshakes: dfp_read/dfp_write are held until the one-cycle dfp_resp; a bmem_read
  // command or a bmem_write beat transfers on a cycle where bmem_ready is also high;
  // bmem_rvalid carries one read beat per cycle and has no back-pressure.
  logic [ADDR_BITS-1:0] dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;

  logic [ADDR_BITS-1:0] bmem_addr;
  logic                 bmem_read;
  logic                 bmem_write;
  logic [BEAT_BITS-1:0] bmem_wdata;
  logic                 bmem_ready;
  logic [ADDR_BITS-1:0] bmem_raddr;
  logic [BEAT_BITS-1:0] bmem_rdata;
  logic                 bmem_rvalid;

  logic                 addr_err;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output addr_err
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  addr_err
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Serialises whole-line DFP reads/writes into BEATS-beat bmem bursts and reassembles reads.
// Optional CACHELINE_ADAPTER_ADDR_CHECK_EN: flag returning bursts whose address tag mismatches.
module cacheline_adapter #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adapter_if.slave   bus,
  output logic [2:0]           dbg_state
);
  localparam int BEATS    = LINE_BITS / BEAT_BITS;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_CMD   = 3'd2,
    RD_WAIT  = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0] line_q;
  logic                 err_q;
  logic                 cnt_last;
  logic                 rd_cmd, wr_beat, resp;

  assign cnt_last = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.dfp_write || bus.dfp_read)
            addr_q <= {bus.dfp_addr[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
          if (bus.dfp_write)
            line_q <= bus.dfp_wdata;
        end
        WR_BURST: begin
          if (bus.bmem_ready)
            cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
        end
        RD_WAIT: begin
          if (bus.bmem_rvalid) begin
            line_q[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] <= bus.bmem_rdata;
            cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
            if (bus.bmem_raddr != addr_q)
              err_q <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Write takes priority when both requests are raised together.
  always_comb begin
    state_d = state_q;
    rd_cmd  = 1'b0;
    wr_beat = 1'b0;
    resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dfp_write)     state_d = WR_BURST;
        else if (bus.dfp_read) state_d = RD_CMD;
      end
      WR_BURST: begin
        wr_beat = 1'b1;
        if (bus.bmem_ready && cnt_last) state_d = RESP;
      end
      RD_CMD: begin
        rd_cmd = 1'b1;
        if (bus.bmem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.bmem_rvalid && cnt_last) state_d = RESP;
      end
      RESP: begin
        resp    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dfp_resp   = resp;
  assign bus.dfp_rdata  = line_q;
  assign bus.bmem_addr  = addr_q;
  assign bus.bmem_read  = rd_cmd;
  assign bus.bmem_write = wr_beat;
  assign bus.bmem_wdata = line_q[int'(cnt_q)*BEAT_BITS +: BEAT_BITS];
  assign dbg_state      = state_q;

`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
  assign bus.addr_err = err_q;
  logic unused_bits;
  assign unused_bits = ^bus.dfp_addr[OFF_BITS-1:0];
`else
  assign bus.addr_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{bus.dfp_addr[OFF_BITS-1:0], bus.bmem_raddr, err_q};
`endif
endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: write beats and read lines are queued when driven
// and compared when the adapter emits them.
module tb_cacheline_adapter;
  localparam int AB = 32;
  localparam int LB = 256;
  localparam int BB = 64;
  localparam int NB = LB / BB;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  cacheline_adapter_if #(.ADDR_BITS(AB), .LINE_BITS(LB), .BEAT_BITS(BB)) bus ();

  cacheline_adapter #(.ADDR_BITS(AB), .LINE_BITS(LB), .BEAT_BITS(BB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  int rd_cmd_cnt = 0;
  int wr_acc   = 0;
  logic          cur_read = 1'b0;
  logic [AB-1:0] exp_addr = '0;
  logic [BB-1:0] wbeat_q[$];
  logic [LB-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: compare everything the adapter produces against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bmem_write) begin
        if (wbeat_q.size() == 0) check("wbeat_unexp", LB'(1), LB'(0));
        else if (bus.bmem_ready) begin
          check("wbeat", LB'(bus.bmem_wdata), LB'(wbeat_q.pop_front()));
          check("wr_addr", LB'(bus.bmem_addr), LB'(exp_addr));
          wr_acc++;
        end else check("wbeat_hold", LB'(bus.bmem_wdata), LB'(wbeat_q[0]));
      end
      if (bus.bmem_read) begin
        rd_cmd_cnt++;
        check("rd_addr", LB'(bus.bmem_addr), LB'(exp_addr));
      end
      if (bus.dfp_resp) begin
        resp_cnt++;
        resp_cyc = cyc;
        if (cur_read) begin
          if (exp_q.size() == 0) check("resp_unexp", LB'(1), LB'(0));
          else check("rline", bus.dfp_rdata, exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int j = 0; j < LB / 32; j++) l[j*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic do_write(input logic [AB-1:0] addr, input logic [LB-1:0] line,
                          input bit both, input int stall_beat, input bit rand_bp);
    int acc0, resp0, rd0, req_cyc, stall_left;
    for (int b = 0; b < NB; b++) wbeat_q.push_back(line[b*BB +: BB]);
    exp_addr = {addr[AB-1:5], 5'b0};
    cur_read = 1'b0;
    bus.dfp_addr  = addr;
    bus.dfp_wdata = line;
    bus.dfp_write = 1'b1;
    bus.dfp_read  = both;
    acc0 = wr_acc; resp0 = resp_cnt; rd0 = rd_cmd_cnt; req_cyc = cyc; stall_left = 2;
    for (int i = 0; i < 100 && resp_cnt == resp0; i++) begin
      @(posedge clk); #1;
      if (rand_bp) bus.bmem_ready = ($urandom_range(0, 3) != 0);
      else if (stall_beat >= 0 && (wr_acc - acc0) == stall_beat && stall_left > 0) begin
        bus.bmem_ready = 1'b0;
        stall_left--;
      end else bus.bmem_ready = 1'b1;
    end
    if (resp_cnt == resp0) check("wr_timeout", LB'(0), LB'(1));
    check("wr_beats", LB'(wr_acc - acc0), LB'(NB));
    if (stall_beat < 0 && !rand_bp) check("wr_latency", LB'(resp_cyc - req_cyc), LB'(NB + 1));
    if (both) check("both_no_read", LB'(rd_cmd_cnt - rd0), LB'(0));
    bus.dfp_write  = 1'b0;
    bus.dfp_read   = 1'b0;
    bus.bmem_ready = 1'b1;
  endtask

  task automatic wait_cmd();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.bmem_read && bus.bmem_ready;
    end
    if (!found) check("rd_cmd_timeout", LB'(0), LB'(1));
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [AB-1:0] addr, input logic [LB-1:0] line,
                         input int lat, input int gap, input bit bad_tag);
    int resp0, rd0;
    exp_q.push_back(line);
    exp_addr = {addr[AB-1:5], 5'b0};
    cur_read = 1'b1;
    bus.dfp_addr = addr;
    bus.dfp_read = 1'b1;
    resp0 = resp_cnt; rd0 = rd_cmd_cnt;
    wait_cmd();
    repeat (lat) begin @(posedge clk); #1; end
    for (int b = 0; b < NB; b++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = line[b*BB +: BB];
      bus.bmem_raddr  = bad_tag ? 32'h2000_0000 : exp_addr;
      @(posedge clk); #1;
      bus.bmem_rvalid = 1'b0;
      if (b < NB - 1) repeat (gap) begin @(posedge clk); #1; end
    end
    for (int i = 0; i < 20 && resp_cnt == resp0; i++) begin @(posedge clk); #1; end
    if (resp_cnt == resp0) check("rd_timeout", LB'(0), LB'(1));
    check("rd_cmd_once", LB'(rd_cmd_cnt - rd0), LB'(1));
    bus.dfp_read = 1'b0;
    cur_read = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LB-1:0] line;
    logic [LB-1:0] exp_err;
    int resp_b;

    rst = 1'b1;
    bus.dfp_addr = '0; bus.dfp_read = 1'b0; bus.dfp_write = 1'b0; bus.dfp_wdata = '0;
    bus.bmem_ready = 1'b1; bus.bmem_raddr = '0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp",  LB'(bus.dfp_resp),   LB'(0));
    check("rst_read",  LB'(bus.bmem_read),  LB'(0));
    check("rst_write", LB'(bus.bmem_write), LB'(0));
    check("rst_err",   LB'(bus.addr_err),   LB'(0));
    check("rst_rdata", bus.dfp_rdata,       LB'(0));
    check("rst_state", LB'(dbg_state),      LB'(0));
    @(posedge clk); #1;

    // Plain write with memory always ready
    line = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
            64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    do_write(32'h1000_0044, line, 1'b0, -1, 1'b0);

    // Read with 3-cycle latency
    line = {64'd4, 64'd3, 64'd2, 64'd1};
    do_read(32'h1000_0080, line, 3, 0, 1'b0);

    // Two-cycle stall before beat 2
    do_write(32'h1000_00C0, rand_line(), 1'b0, 2, 1'b0);

    // Simultaneous read and write: write wins
    do_write(32'h1000_0100, rand_line(), 1'b1, -1, 1'b0);

    // Writeback immediately followed by fetch
    resp_b = resp_cnt;
    do_write(32'h3000_0020, rand_line(), 1'b0, -1, 1'b0);
    do_read(32'h3000_1000, rand_line(), 1, 0, 1'b0);
    check("wb_fetch_resps", LB'(resp_cnt - resp_b), LB'(2));

    // Stray read beats while idle must not disturb the next read
    bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) begin @(posedge clk); #1; end
    bus.bmem_rvalid = 1'b0;
    do_read(32'h1000_0140, rand_line(), 0, 0, 1'b0);

    // Gapped read aborted by reset after two beats
    resp_b = resp_cnt;
    exp_addr = 32'h1000_0180;
    cur_read = 1'b1;
    bus.dfp_addr = 32'h1000_0180;
    bus.dfp_read = 1'b1;
    wait_cmd();
    for (int b = 0; b < 2; b++) begin
      bus.bmem_rvalid = 1'b1; bus.bmem_rdata = 64'h5555_0000_0000_0000 | 64'(b);
      bus.bmem_raddr = exp_addr;
      @(posedge clk); #1;
      bus.bmem_rvalid = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1; bus.dfp_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", LB'(dbg_state), LB'(0));
    check("abort_rdata", bus.dfp_rdata, LB'(0));
    repeat (4) @(negedge clk);
    check("abort_no_resp", LB'(resp_cnt - resp_b), LB'(0));
    cur_read = 1'b0;
    @(posedge clk); #1;
    do_read(32'h1000_0180, rand_line(), 0, 1, 1'b0);

    // Random traffic with random back-pressure, latency and gaps
    for (int k = 0; k < 4; k++) begin
      do_write($urandom, rand_line(), 1'b0, -1, 1'b1);
      do_read($urandom, rand_line(), $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);
    end
    check("err_clean", LB'(bus.addr_err), LB'(0));

    // Mismatched return tag
`ifdef CACHELINE_ADAPTER_ADDR_CHECK_EN
    exp_err = LB'(1);
`else
    exp_err = LB'(0);
`endif
    do_read(32'h1000_0040, rand_line(), 2, 0, 1'b1);
    check("addr_err_set", LB'(bus.addr_err), exp_err);
    do_read(32'h1000_0040, rand_line(), 0, 0, 1'b0);
    check("addr_err_sticky", LB'(bus.addr_err), exp_err);
    check("wbeat_q_empty", LB'(wbeat_q.size()), LB'(0));
    check("exp_q_empty", LB'(exp_q.size()), LB'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
